// File: rtl/capture_sequencer.sv
// capture_sequencer: composite-sync driven line/pixel capture timing.
// Define LOCK_WATCHDOG_EN to drop lock after 8192 cycles without hsync.
module capture_sequencer #(
  parameter int H_START       = 120,
  parameter int H_PIXELS      = 640,
  parameter int V_START       = 23,
  parameter int V_LINES       = 256,
  parameter int VSYNC_MIN_LOW = 600,
  parameter int LINE_HALF     = 1920
) (
  input  logic       sysClock,
  input  logic       reset,
  input  logic       pixelClockX1_en,
  input  logic       hsync,
  input  logic       csync,
  output logic       captureEnable,
  output logic [9:0] writeAddress,
  output logic [8:0] lineNumber,
  output logic       lineDone,
  output logic       frameStart,
  output logic       field,
  output logic       locked
);

  typedef enum logic [2:0] {
    UNLOCKED,
    VBLANK,
    LINE_WAIT,
    CAPTURE,
    LINE_END
  } state_t;

  localparam logic [11:0] LP_VMIN   = 12'(VSYNC_MIN_LOW - 1);
  localparam logic [11:0] LP_HALF   = 12'(LINE_HALF);
  localparam logic [8:0]  LP_VSTART = 9'(V_START);
  localparam logic [8:0]  LP_VLAST  = 9'(V_LINES - 1);
  localparam logic [9:0]  LP_HLAST  = 10'(H_PIXELS - 1);
  // Leave LINE_WAIT one enable early so the H_START-th enable is captured
  localparam logic [9:0]  LP_HGO    = 10'(H_START - 2);

  state_t      r_state;
  state_t      w_state_nx;
  logic [11:0] r_low_cnt;
  logic [11:0] r_hcount;
  logic        r_vsync;
  logic [8:0]  r_vcnt;
  logic [8:0]  w_vcnt_nx;
  logic [8:0]  r_line;
  logic [8:0]  w_line_nx;
  logic [9:0]  r_hpix;
  logic [9:0]  w_hpix_nx;
  logic [9:0]  r_waddr;
  logic [9:0]  w_waddr_nx;
  logic        r_done;
  logic        w_done_nx;
  logic        r_field;
  logic        w_field_nx;
  logic        r_locked;
  logic        w_locked_nx;
  logic        w_timeout;
  logic        w_line_last;

  always_ff @(posedge sysClock) begin
    if (reset) begin
      r_low_cnt <= '0;
      r_vsync   <= 1'b0;
      r_hcount  <= '0;
    end else begin
      if (csync)
        r_low_cnt <= '0;
      else if (r_low_cnt != '1)
        r_low_cnt <= r_low_cnt + 12'd1;
      r_vsync <= !csync && (r_low_cnt == LP_VMIN);
      if (hsync)
        r_hcount <= '0;
      else if (r_hcount != '1)
        r_hcount <= r_hcount + 12'd1;
    end
  end

`ifdef LOCK_WATCHDOG_EN
  logic [12:0] r_wd;

  always_ff @(posedge sysClock) begin
    if (reset || hsync)
      r_wd <= '0;
    else
      r_wd <= r_wd + 13'd1;
  end

  assign w_timeout = (r_wd == '1) && !hsync;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge sysClock) begin
    if (reset) begin
      r_state  <= UNLOCKED;
      r_vcnt   <= '0;
      r_line   <= '0;
      r_hpix   <= '0;
      r_waddr  <= '0;
      r_done   <= 1'b0;
      r_field  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_vcnt   <= w_vcnt_nx;
      r_line   <= w_line_nx;
      r_hpix   <= w_hpix_nx;
      r_waddr  <= w_waddr_nx;
      r_done   <= w_done_nx;
      r_field  <= w_field_nx;
      r_locked <= w_locked_nx;
    end
  end

  assign w_line_last = (r_line == LP_VLAST);

  always_comb begin
    w_state_nx  = r_state;
    w_vcnt_nx   = r_vcnt;
    w_line_nx   = r_line;
    w_hpix_nx   = r_hpix;
    w_waddr_nx  = r_waddr;
    w_done_nx   = 1'b0;
    w_field_nx  = r_field;
    w_locked_nx = r_locked;
    if (hsync) begin
      w_hpix_nx = '0;
      if (r_vcnt != '1)
        w_vcnt_nx = r_vcnt + 9'd1;
    end
    if (r_vsync) begin
      w_state_nx  = VBLANK;
      w_vcnt_nx   = '0;
      w_line_nx   = '0;
      w_hpix_nx   = '0;
      w_waddr_nx  = '0;
      w_locked_nx = 1'b1;
      w_field_nx  = (r_hcount >= LP_HALF);
    end else if (w_timeout) begin
      w_state_nx  = UNLOCKED;
      w_vcnt_nx   = '0;
      w_line_nx   = '0;
      w_hpix_nx   = '0;
      w_waddr_nx  = '0;
      w_locked_nx = 1'b0;
    end else begin
      unique case (r_state)
        UNLOCKED: ;
        VBLANK: begin
          if (hsync && (w_vcnt_nx == LP_VSTART))
            w_state_nx = LINE_WAIT;
        end
        LINE_WAIT: begin
          if (!hsync && pixelClockX1_en) begin
            if (r_hpix == LP_HGO) begin
              w_state_nx = CAPTURE;
              w_hpix_nx  = '0;
            end else begin
              w_hpix_nx = r_hpix + 10'd1;
            end
          end
        end
        CAPTURE: begin
          if (hsync) begin
            // Short line: close it and realign to this hsync
            w_done_nx  = 1'b1;
            w_waddr_nx = '0;
            if (w_line_last) begin
              w_state_nx = VBLANK;
            end else begin
              w_line_nx  = r_line + 9'd1;
              w_state_nx = LINE_WAIT;
            end
          end else if (pixelClockX1_en) begin
            if (r_waddr == LP_HLAST) begin
              w_done_nx  = 1'b1;
              w_waddr_nx = '0;
              w_state_nx = w_line_last ? VBLANK : LINE_END;
            end else begin
              w_waddr_nx = r_waddr + 10'd1;
            end
          end
        end
        LINE_END: begin
          if (hsync) begin
            w_line_nx  = r_line + 9'd1;
            w_state_nx = LINE_WAIT;
          end
        end
        default: w_state_nx = UNLOCKED;
      endcase
    end
  end

  assign captureEnable = pixelClockX1_en && (r_state == CAPTURE);
  assign writeAddress  = r_waddr;
  assign lineNumber    = r_line;
  assign lineDone      = r_done;
  assign frameStart    = r_vsync;
  assign field         = r_field;
  assign locked        = r_locked;

endmodule
